// File: rtl/instr_decode_ctrl.sv
// -----------------------------------------------------------------------------
// instr_decode_ctrl
//
// Multi-cycle control FSM for a small RV32I datapath. It requests an
// instruction fetch, waits for the fetch stage to report a stable IR,
// registers the decoded fields, optionally waits on data memory, and closes
// each instruction with a single write-back cycle that commits the next PC.
//
// Parameters
//   MEM_TIMEOUT   max MEM cycles waited for mem_ready (1..15, 4-bit counter)
//
// Build option
//   ILLEGAL_TRAP_EN  when defined, an unrecognised opcode raises 'illegal'
//                    and parks the FSM in TRAP until reset. When undefined,
//                    such an opcode retires as a NOP (PC+4, no register write)
//                    and 'illegal' is tied low.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start             level; allows leaving IDLE and chaining instructions
//   IR, W_IR_valid    instruction word and its "updated and stable" strobe
//   NZCV              ALU flags {N,Z,C,V}, looked at only in WB
//   mem_ready         data memory access complete
//   write_ir          one-cycle fetch request (FETCH)
//   write_pc          one-cycle PC commit (WB)
//   pc_sel            0 = PC+4, 1 = branch/jump target (meaningful in WB)
//   write_reg         register-file write strobe (WB)
//   write_mem         data-memory write strobe (MEM, stores only)
//   alu_op, rs1, rs2, rd, imm   fields registered in DECODE
//   state             current FSM state (debug / checker visibility)
//   mem_err           sticky memory-timeout flag, cleared only by reset
//   illegal           illegal-opcode flag
//
// Handshakes: W_IR_valid is a level qualifier consumed only in WAIT_IR, and
// mem_ready is consumed only in MEM; neither has a ready back-pressure signal,
// and both are ignored in every other state. All four strobes are Moore
// outputs derived from registered state only.
// -----------------------------------------------------------------------------
module instr_decode_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] IR,
  input  logic        W_IR_valid,
  input  logic [3:0]  NZCV,
  input  logic        mem_ready,
  output logic        write_ir,
  output logic        write_pc,
  output logic        pc_sel,
  output logic        write_reg,
  output logic        write_mem,
  output logic [3:0]  alu_op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [2:0]  state,
  output logic        mem_err,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT_IR = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC    = 3'd4,
    S_MEM     = 3'd5,
    S_WB      = 3'd6,
    S_TRAP    = 3'd7
  } state_t;

  // Instruction class captured in DECODE; CL_NONE marks an unrecognised opcode.
  typedef enum logic [2:0] {
    CL_NONE   = 3'd0,
    CL_ALU    = 3'd1,
    CL_UPPER  = 3'd2,
    CL_LOAD   = 3'd3,
    CL_STORE  = 3'd4,
    CL_BRANCH = 3'd5,
    CL_JAL    = 3'd6,
    CL_JALR   = 3'd7
  } class_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  // The counter starts at 0 on the first MEM cycle, so the last allowed
  // cycle is MEM_TIMEOUT-1.
  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  class_t      cls_q, dec_cls;
  logic [2:0]  funct3_q;
  logic [3:0]  mem_cnt_q;
  logic        armed_q;
  logic        mem_to_q;     // this instruction timed out in MEM
  logic        mem_err_q;
  logic        mem_timeout;
  logic        br_taken;
  logic [31:0] dec_imm;
  logic [3:0]  dec_alu;

  // ---------------------------------------------------------------------------
  // Combinational decode of the IR presented during DECODE.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_cls = CL_NONE;
    dec_imm = '0;
    dec_alu = ALU_ADD;
    unique case (IR[6:0])
      OPC_LUI: begin
        dec_cls = CL_UPPER;
        dec_imm = {IR[31:12], 12'b0};
        dec_alu = ALU_PASS;
      end
      OPC_AUIPC: begin
        dec_cls = CL_UPPER;
        dec_imm = {IR[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_cls = CL_JAL;
        dec_imm = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec_cls = CL_JALR;
        dec_imm = {{20{IR[31]}}, IR[31:20]};
      end
      OPC_BRANCH: begin
        dec_cls = CL_BRANCH;
        dec_imm = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
        dec_alu = ALU_SUB;
      end
      OPC_LOAD: begin
        dec_cls = CL_LOAD;
        dec_imm = {{20{IR[31]}}, IR[31:20]};
      end
      OPC_STORE: begin
        dec_cls = CL_STORE;
        dec_imm = {{20{IR[31]}}, IR[31:25], IR[11:7]};
      end
      OPC_OPIMM: begin
        dec_cls = CL_ALU;
        dec_imm = {{20{IR[31]}}, IR[31:20]};
        // Only the shift-right form uses IR[30] as an op modifier (SRAI);
        // for the other immediates it is just an immediate bit.
        dec_alu = {(IR[14:12] == 3'b101) & IR[30], IR[14:12]};
      end
      OPC_OP: begin
        dec_cls = CL_ALU;
        dec_alu = {IR[30], IR[14:12]};
      end
      default: begin
        dec_cls = CL_NONE;
      end
    endcase
  end

  assign mem_timeout = (state_q == S_MEM) && !mem_ready && (mem_cnt_q == TIMEOUT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start && armed_q) state_d = S_FETCH;
      S_FETCH:   state_d = S_WAIT_IR;
      S_WAIT_IR: if (W_IR_valid) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (dec_cls == CL_NONE) state_d = S_TRAP;
`endif
      end
      S_EXEC: begin
        if (cls_q == CL_LOAD || cls_q == CL_STORE) state_d = S_MEM;
        else                                       state_d = S_WB;
      end
      S_MEM:     if (mem_ready || mem_timeout) state_d = S_WB;
      S_WB:      state_d = start ? S_FETCH : S_IDLE;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath-control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      cls_q     <= CL_NONE;
      funct3_q  <= '0;
      mem_cnt_q <= '0;
      mem_to_q  <= 1'b0;
      mem_err_q <= 1'b0;
      alu_op    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imm       <= '0;
    end else begin
      state_q <= state_d;
      // One idle edge after reset release before IDLE may be left.
      armed_q <= 1'b1;

      if (state_q == S_DECODE) begin
        cls_q    <= dec_cls;
        funct3_q <= IR[14:12];
        alu_op   <= dec_alu;
        rs1      <= IR[19:15];
        rs2      <= IR[24:20];
        rd       <= IR[11:7];
        imm      <= dec_imm;
        mem_to_q <= 1'b0;
      end

      if (state_q == S_MEM && !mem_ready && !mem_timeout) mem_cnt_q <= mem_cnt_q + 4'd1;
      else                                                mem_cnt_q <= '0;

      if (mem_timeout) begin
        mem_err_q <= 1'b1;
        mem_to_q  <= 1'b1;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            illegal_q <= 1'b0;
    else if (state_q == S_DECODE && dec_cls == CL_NONE) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Branch condition from the flags present during WB
  // ---------------------------------------------------------------------------
  always_comb begin
    br_taken = 1'b0;
    unique case (funct3_q)
      3'b000:  br_taken = NZCV[2];               // BEQ  Z
      3'b001:  br_taken = !NZCV[2];              // BNE  !Z
      3'b100:  br_taken = NZCV[3] != NZCV[0];    // BLT  N!=V
      3'b101:  br_taken = NZCV[3] == NZCV[0];    // BGE  N==V
      3'b110:  br_taken = !NZCV[1];              // BLTU !C
      3'b111:  br_taken = NZCV[1];               // BGEU C
      default: br_taken = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    write_ir  = (state_q == S_FETCH);
    write_pc  = (state_q == S_WB);
    write_mem = (state_q == S_MEM) && (cls_q == CL_STORE);
    write_reg = 1'b0;
    pc_sel    = 1'b0;
    if (state_q == S_WB) begin
      write_reg = (rd != 5'd0) &&
                  ((cls_q == CL_ALU) || (cls_q == CL_UPPER) ||
                   (cls_q == CL_JAL) || (cls_q == CL_JALR)  ||
                   ((cls_q == CL_LOAD) && !mem_to_q));
      pc_sel    = (cls_q == CL_JAL) || (cls_q == CL_JALR) ||
                  ((cls_q == CL_BRANCH) && br_taken);
    end
  end

  assign state   = state_q;
  assign mem_err = mem_err_q;

endmodule

// File: doc/instr_decode_ctrl.md
INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max cycles waited in MEM for mem_ready (4-bit counter, 1..15).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 start  in  1  level; allows leaving IDLE.
REQ-005 IR  in  32  instruction word from fetch stage (RV32I encoding).
REQ-006 W_IR_valid  in  1  fetch stage reports IR updated and stable.
REQ-007 NZCV  in  4  ALU flags {N,Z,C,V} from the previous EXEC cycle.
REQ-008 mem_ready  in  1  data memory access complete.
REQ-009 write_ir  out  1  one-cycle pulse requesting instruction fetch.
REQ-010 write_pc  out  1  one-cycle pulse committing next PC.
REQ-011 pc_sel  out  1  0 = PC+4, 1 = branch/jump target; valid while write_pc=1.
REQ-012 write_reg / write_mem  out  1 each  register-file write / data-memory write strobes.
REQ-013 alu_op  out  4  ALU operation code; rs1, rs2, rd  out  5 each; imm  out  32 sign-extended immediate.
REQ-014 state  out  3  current FSM state; mem_err  out  1 sticky timeout flag; illegal  out  1 illegal-opcode flag.

Function
REQ-015 States (encoding): IDLE=0, FETCH=1, WAIT_IR=2, DECODE=3, EXEC=4, MEM=5, WB=6, TRAP=7.
REQ-016 IDLE -> FETCH when start=1; else stay.
REQ-017 FETCH: write_ir=1 for exactly one cycle, then WAIT_IR.
REQ-018 WAIT_IR: stay until W_IR_valid=1, then DECODE; W_IR_valid in any other state is ignored.
REQ-019 DECODE: register rs1/rs2/rd/alu_op/imm from IR in one cycle (I/S/B/U/J immediate formats, sign bit IR[31]); next EXEC.
REQ-020 EXEC: one cycle; loads/stores -> MEM, all other legal opcodes -> WB.
REQ-021 MEM: write_mem=1 every cycle for stores; leave to WB on mem_ready=1; 4-bit counter counts cycles, on reaching MEM_TIMEOUT without mem_ready set mem_err=1 and go to WB.
REQ-022 WB: single cycle; write_pc=1; write_reg=1 for OP, OP-IMM, LOAD (unless mem_err set this instruction), LUI, AUIPC, JAL, JALR, and only when rd!=0; next FETCH if start=1, else IDLE.
REQ-023 pc_sel=1 in WB for JAL, JALR, and taken branches: BEQ Z=1, BNE Z=0, BLT N!=V, BGE N==V, BLTU C=0, BGEU C=1.
REQ-024 Flags sampled in WB only; NZCV changes outside WB have no effect.
REQ-025 Decode latency: IR accepted to write_pc = 3 cycles for non-memory instructions, 3+k for memory (k = MEM cycles, 1..MEM_TIMEOUT).
REQ-026 Outputs write_ir, write_pc, write_reg, write_mem are decoded from registered state only (Moore), never combinationally from inputs.
REQ-027 mem_err clears only on reset.

Reset
REQ-028 rst low asynchronously forces state=IDLE, all strobes 0, pc_sel=0, alu_op/rs1/rs2/rd/imm=0, counter=0, mem_err=0, illegal=0.
REQ-029 Reset asserted mid-instruction (any state, including MEM) abandons the instruction with no write_pc or write_reg pulse.
REQ-030 After rst rises, first FETCH no earlier than the second rising clk edge with start=1.

Configuration
REQ-031 Macro ILLEGAL_TRAP_EN defined: unrecognised opcode in DECODE sets illegal=1 and enters TRAP, which holds (all strobes 0) until reset.
REQ-032 ILLEGAL_TRAP_EN undefined: unrecognised opcode treated as NOP (EXEC -> WB, write_pc with pc_sel=0, no write_reg); illegal tied 0; TRAP state unreachable.

Verification
REQ-033 Reset then start=1, IR=0x00500093 (addi x1,x0,5), W_IR_valid after 2 cycles -> write_ir pulse, WB with write_reg=1, rd=1, imm=5, pc_sel=0.
REQ-034 IR=0x00208463 (beq x1,x2,+8), NZCV=4'b0100 -> pc_sel=1, imm=8; repeat with NZCV=0 -> pc_sel=0; no write_reg.
REQ-035 IR=0x0020A023 (sw), mem_ready held 0 -> write_mem high 15 cycles, mem_err=1, write_pc pulse, no write_reg.
REQ-036 rst driven low during MEM between clock edges -> state=0 and strobes 0 immediately; no write_pc.
REQ-037 IR=0xFFFFFFFF: with ILLEGAL_TRAP_EN -> illegal=1, state=7 held for 20 cycles; without -> write_pc pulse, pc_sel=0, next FETCH.
REQ-038 addi to rd=0 (IR=0x00500013) -> write_reg stays 0 in WB, write_pc=1.
